fifo_wr_adapter: RTL

FIFO_WR_ADAPTER -- requirements
Module: fifo_wr_adapter

---
 rtl/nou_fifo_pkg.sv | 12 +
 rtl/fifo_wr_adapter_if.sv | 27 ++
 rtl/fifo_wr_adapter.sv | 89 ++++++++
 3 files changed

// File: rtl/nou_fifo_pkg.sv
// rtl/nou_fifo_pkg.sv - shared constants for the FIFO write skid adapter
package nou_fifo_pkg;

    // Depth of the in-order skid buffer sitting in front of the FIFO.
    localparam int FIFO_WR_SKID_DEPTH = 2;

    // Width of the entry counter, wide enough for 0..FIFO_WR_SKID_DEPTH.
    localparam int FIFO_WR_CNT_W = $clog2(FIFO_WR_SKID_DEPTH + 1);

    typedef logic [FIFO_WR_CNT_W-1:0] fifo_wr_cnt_t;

endpackage : nou_fifo_pkg

// File: rtl/fifo_wr_adapter_if.sv
// rtl/fifo_wr_adapter_if.sv - upstream and FIFO-side signal bundle for the adapter
interface fifo_wr_adapter_if
    import nou_fifo_pkg::*;
#(
    parameter int WIDTH = 512
);
    logic             valid;
    logic [WIDTH-1:0] din;
    logic             ready;
    logic             flush;
    logic             fifo_full;
    logic             fifo_wr_en;
    logic [WIDTH-1:0] fifo_din;
    fifo_wr_cnt_t     count;

    // Producer side plus the FIFO status it presents to the adapter.
    modport master (
        output valid, din, flush, fifo_full,
        input  ready, fifo_wr_en, fifo_din, count
    );

    // Adapter side.
    modport slave (
        input  valid, din, flush, fifo_full,
        output ready, fifo_wr_en, fifo_din, count
    );
endinterface : fifo_wr_adapter_if

// File: rtl/fifo_wr_adapter.sv
// rtl/fifo_wr_adapter.sv - 2-entry skid buffer feeding a standard FIFO write port
module fifo_wr_adapter
    import nou_fifo_pkg::*;
#(
    parameter int WIDTH = 512
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] din_i,
    output logic             ready_o,
    input  logic             flush_i,
    input  logic             fifo_full_i,
    output logic             fifo_wr_en_o,
    output logic [WIDTH-1:0] fifo_din_o,
    output fifo_wr_cnt_t     count_o
);

    localparam fifo_wr_cnt_t CNT_ZERO = '0;
    localparam fifo_wr_cnt_t CNT_ONE  = fifo_wr_cnt_t'(1);
    localparam fifo_wr_cnt_t CNT_FULL = fifo_wr_cnt_t'(FIFO_WR_SKID_DEPTH);

    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    fifo_wr_cnt_t     count_q, count_d;
    logic             push;
    logic             pop;

    // ready depends only on the count register, so upstream never sees
    // a combinational path from fifo_full_i or valid_i.
    assign ready_o      = (count_q != CNT_FULL);
    assign push         = valid_i && ready_o && !flush_i;
    assign pop          = (count_q != CNT_ZERO) && !fifo_full_i && !flush_i;
    assign fifo_wr_en_o = pop;
    assign fifo_din_o   = head_q;
    assign count_o      = count_q;

    // Next-state for head/tail/count; head always holds the oldest word.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            count_d = CNT_ZERO;
        end else begin
            case (count_q)
                CNT_ZERO: begin
                    if (push) begin
                        head_d  = din_i;
                        count_d = CNT_ONE;
                    end
                end
                CNT_ONE: begin
                    if (push && pop) begin
                        head_d = din_i;
                    end else if (push) begin
                        tail_d  = din_i;
                        count_d = CNT_FULL;
                    end else if (pop) begin
                        count_d = CNT_ZERO;
                    end
                end
                CNT_FULL: begin
                    if (pop) begin
                        head_d  = tail_q;
                        count_d = CNT_ONE;
                    end
                end
                default: begin
                    count_d = CNT_ZERO;
                end
            endcase
        end
    end

    // Buffer state registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= CNT_ZERO;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule : fifo_wr_adapter
